// File: rtl/slot_config_pkg.sv
// Shared definitions for the slot configuration controller.
//   - Host register addresses (KEY / PTR / DATA / STATUS)
//   - Controller state encoding
//   - Default unlock key
//   - STATUS byte packing helper
package slot_config_pkg;

  localparam logic [1:0] REG_KEY    = 2'd0;
  localparam logic [1:0] REG_PTR    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [7:0] UNLOCK_KEY_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_WAIT,
    WR,
    RD_SETUP,
    RD_WAIT,
    RD_CAP
  } state_t;

  // STATUS register layout: {5'b0, write_waiting, unlocked, init_done}
  function automatic logic [7:0] status_byte(input logic waiting,
                                             input logic unlocked,
                                             input logic init_done);
    return {5'b0, waiting, unlocked, init_done};
  endfunction

endpackage

// File: rtl/slot_config_ctrl.sv
// slot_config_ctrl
//   Sole driver of the virtual slot controller's configuration port. After
//   reset it loads DEFAULT_CARDS into slots 0..7, then serves a small host
//   register bus for locked, auto-incrementing card table access. Table
//   writes wait for the Apple II bus to leave slot space (bounded by
//   QUIET_TIMEOUT) so a card id never changes during an access.
//
// Ports
//   clk_logic, system_reset_n : clock, asynchronous active-low reset
//   host_addr   [1:0] : 0 KEY, 1 PTR, 2 DATA, 3 STATUS
//   host_wr / host_rd : one-cycle request pulses
//   host_wdata  [7:0] : write data
//   host_rdata  [7:0] : read data, valid with host_ready
//   host_ready        : one-cycle completion pulse per accepted request
//   a2_slot_busy      : Apple II bus is decoding slot space
//   cfg_slot    [2:0] : slot index to slot controller
//   cfg_card    [7:0] : card id to write
//   cfg_wr            : one-cycle table write strobe
//   cfg_card_o  [7:0] : registered readback of slot cfg_slot
//   init_done         : boot table load complete
module slot_config_ctrl
  import slot_config_pkg::*;
#(
  parameter logic [63:0] DEFAULT_CARDS = 64'h05_00_00_02_00_00_03_00,
  parameter logic [7:0]  UNLOCK_KEY    = UNLOCK_KEY_DEFAULT,
  parameter int unsigned QUIET_TIMEOUT = 16
) (
  input  logic       clk_logic,
  input  logic       system_reset_n,
  input  logic [1:0] host_addr,
  input  logic       host_wr,
  input  logic       host_rd,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_ready,
  input  logic       a2_slot_busy,
  output logic [2:0] cfg_slot,
  output logic [7:0] cfg_card,
  output logic       cfg_wr,
  input  logic [7:0] cfg_card_o,
  output logic       init_done
);

  localparam int CNT_W = $clog2(QUIET_TIMEOUT + 1);

  state_t           state_q,      state_d;
  logic [2:0]       ptr_q,        ptr_d;
  logic             unlocked_q,   unlocked_d;
  logic [7:0]       wdata_q,      wdata_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [2:0]       init_slot_q,  init_slot_d;
  logic [2:0]       cfg_slot_q,   cfg_slot_d;
  logic [7:0]       cfg_card_q,   cfg_card_d;
  logic             cfg_wr_q,     cfg_wr_d;
  logic [7:0]       host_rdata_q, host_rdata_d;
  logic             host_ready_q, host_ready_d;
  logic             init_done_q,  init_done_d;

  logic req_wr;
  logic req_rd;
  logic wait_over;

  // Simultaneous read and write is malformed and is ignored outright.
  assign req_wr    = host_wr & ~host_rd;
  assign req_rd    = host_rd & ~host_wr;
  assign wait_over = ~a2_slot_busy || (wait_cnt_q == CNT_W'(QUIET_TIMEOUT - 1));

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    unlocked_d   = unlocked_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    init_slot_d  = init_slot_q;
    cfg_slot_d   = cfg_slot_q;
    cfg_card_d   = cfg_card_q;
    cfg_wr_d     = 1'b0;
    host_rdata_d = host_rdata_q;
    host_ready_d = 1'b0;
    init_done_d  = init_done_q;

    unique case (state_q)
      INIT: begin
        // Bus activity is deliberately ignored here: no card is live yet.
        cfg_wr_d    = 1'b1;
        cfg_slot_d  = init_slot_q;
        cfg_card_d  = DEFAULT_CARDS[{init_slot_q, 3'b000} +: 8];
        init_slot_d = init_slot_q + 3'd1;
        if (init_slot_q == 3'd7) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end

      IDLE: begin
        if (req_wr) begin
          host_ready_d = 1'b1;
          unique case (host_addr)
            REG_KEY:    unlocked_d = (host_wdata == UNLOCK_KEY);
            REG_PTR:    ptr_d      = host_wdata[2:0];
            REG_DATA: begin
              // Locked DATA writes complete silently; unlocked ones defer
              // their completion pulse to the actual table write.
              if (unlocked_q) begin
                host_ready_d = 1'b0;
                wdata_d      = host_wdata;
                wait_cnt_d   = '0;
                state_d      = WR_WAIT;
              end
            end
            REG_STATUS: ;
          endcase
        end else if (req_rd) begin
          host_ready_d = 1'b1;
          unique case (host_addr)
            REG_KEY:    host_rdata_d = {7'b0, unlocked_q};
            REG_PTR:    host_rdata_d = {5'b0, ptr_q};
            REG_DATA: begin
              host_ready_d = 1'b0;
              cfg_slot_d   = ptr_q;
              state_d      = RD_SETUP;
            end
            REG_STATUS: host_rdata_d = status_byte(1'b0, unlocked_q, init_done_q);
          endcase
        end
      end

      WR_WAIT: begin
        if (wait_over) begin
          state_d      = WR;
          cfg_wr_d     = 1'b1;
          cfg_slot_d   = ptr_q;
          cfg_card_d   = wdata_q;
          host_ready_d = 1'b1;
          ptr_d        = ptr_q + 3'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // A STATUS read is the one request served while a write is pending,
          // so the host can observe the wait. It is only taken on a cycle that
          // does not also complete the write, keeping the two pulses distinct.
          if (req_rd && host_addr == REG_STATUS) begin
            host_rdata_d = status_byte(1'b1, unlocked_q, init_done_q);
            host_ready_d = 1'b1;
          end
        end
      end

      WR:       state_d = IDLE;

      RD_SETUP: state_d = RD_WAIT;

      RD_WAIT: begin
        // cfg_card_o has had a full cycle to reflect cfg_slot; the captured
        // value and the completion pulse appear during RD_CAP.
        state_d      = RD_CAP;
        host_rdata_d = cfg_card_o;
        host_ready_d = 1'b1;
        ptr_d        = ptr_q + 3'd1;
      end

      RD_CAP:   state_d = IDLE;

      default:  state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      unlocked_q   <= 1'b0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      init_slot_q  <= '0;
      cfg_slot_q   <= '0;
      cfg_card_q   <= '0;
      cfg_wr_q     <= 1'b0;
      host_rdata_q <= '0;
      host_ready_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      unlocked_q   <= unlocked_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      init_slot_q  <= init_slot_d;
      cfg_slot_q   <= cfg_slot_d;
      cfg_card_q   <= cfg_card_d;
      cfg_wr_q     <= cfg_wr_d;
      host_rdata_q <= host_rdata_d;
      host_ready_q <= host_ready_d;
      init_done_q  <= init_done_d;
    end
  end

  assign cfg_slot   = cfg_slot_q;
  assign cfg_card   = cfg_card_q;
  assign cfg_wr     = cfg_wr_q;
  assign host_rdata = host_rdata_q;
  assign host_ready = host_ready_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_slot_config_ctrl.sv
// Testbench for slot_config_ctrl: boot table load, table-driven register
// accesses, and hand-written sequences for deferred/forced writes, back-to-back
// DATA reads and reset during a pending write. A small slot table model stands
// in for the downstream slot controller.
module tb_slot_config_ctrl;
  import slot_config_pkg::*;

  logic       clk_logic = 1'b0;
  logic       system_reset_n;
  logic [1:0] host_addr;
  logic       host_wr;
  logic       host_rd;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       host_ready;
  logic       a2_slot_busy;
  logic [2:0] cfg_slot;
  logic [7:0] cfg_card;
  logic       cfg_wr;
  logic [7:0] cfg_card_o;
  logic       init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  slot_config_ctrl dut (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .host_addr      (host_addr),
    .host_wr        (host_wr),
    .host_rd        (host_rd),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .host_ready     (host_ready),
    .a2_slot_busy   (a2_slot_busy),
    .cfg_slot       (cfg_slot),
    .cfg_card       (cfg_card),
    .cfg_wr         (cfg_wr),
    .cfg_card_o     (cfg_card_o),
    .init_done      (init_done)
  );

  always #5 clk_logic = ~clk_logic;

  // Downstream slot controller: write on strobe, registered readback.
  logic [7:0] slot_mem [8];
  always @(posedge clk_logic) begin
    if (cfg_wr) slot_mem[cfg_slot] <= cfg_card;
    cfg_card_o <= slot_mem[cfg_slot];
  end

  typedef struct packed {
    logic [1:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [1:0] lat;    // cycles to host_ready; 0 = request must be ignored
    logic       chk;    // compare host_rdata
    logic [7:0] rdata;
  } vec_t;

  logic [7:0] boot_cards [8];

  task automatic step();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] addr, input logic wr, input logic rd,
                              input logic [7:0] wdata, input logic [1:0] lat,
                              input logic chk, input logic [7:0] rdata);
    vec_t v;
    v.addr = addr; v.wr = wr; v.rd = rd; v.wdata = wdata;
    v.lat = lat; v.chk = chk; v.rdata = rdata;
    return v;
  endfunction

  // One host access that never writes the table.
  task automatic do_op(input vec_t v, input string tag);
    host_addr  = v.addr;
    host_wr    = v.wr;
    host_rd    = v.rd;
    host_wdata = v.wdata;
    step();
    host_wr = 1'b0;
    host_rd = 1'b0;
    if (v.lat == 2'd0) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        check({tag, " ignored ready"}, {7'b0, host_ready}, 8'h00);
        check({tag, " ignored cfg_wr"}, {7'b0, cfg_wr}, 8'h00);
      end
    end else begin
      for (int k = 1; k <= int'(v.lat); k++) begin
        if (k > 1) step();
        check({tag, " ready"}, {7'b0, host_ready}, (k == int'(v.lat)) ? 8'h01 : 8'h00);
        check({tag, " cfg_wr"}, {7'b0, cfg_wr}, 8'h00);
        if (k == int'(v.lat) && v.chk) check({tag, " rdata"}, host_rdata, v.rdata);
      end
      step();
      check({tag, " ready pulse end"}, {7'b0, host_ready}, 8'h00);
    end
  endtask

  // Runs from just after reset release: expects the 8-slot boot load.
  // A read request is held through INIT and must be dropped.
  task automatic check_init(input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      check({tag, " init cfg_wr"},   {7'b0, cfg_wr},    8'h01);
      check({tag, " init cfg_slot"}, {5'b0, cfg_slot},  8'(i));
      check({tag, " init cfg_card"}, cfg_card,          boot_cards[i]);
      check({tag, " init_done"},     {7'b0, init_done}, (i == 7) ? 8'h01 : 8'h00);
      check({tag, " init ready"},    {7'b0, host_ready}, 8'h00);
    end
    host_rd = 1'b0;
    step();
    check({tag, " post-init cfg_wr"}, {7'b0, cfg_wr},     8'h00);
    check({tag, " post-init ready"},  {7'b0, host_ready}, 8'h00);
  endtask

  vec_t vecs [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 00 expected 01");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;

    boot_cards = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h05};

    // Register accesses after boot: unlocked=0, PTR=0, default table.
    vecs[0]  = mk(REG_KEY,    0, 1, 8'h00, 1, 1, 8'h00);
    vecs[1]  = mk(REG_STATUS, 0, 1, 8'h00, 1, 1, 8'h01);
    vecs[2]  = mk(REG_PTR,    1, 0, 8'h04, 1, 0, 8'h00);
    vecs[3]  = mk(REG_PTR,    0, 1, 8'h00, 1, 1, 8'h04);
    vecs[4]  = mk(REG_DATA,   1, 0, 8'h07, 1, 0, 8'h00);  // locked: dropped
    vecs[5]  = mk(REG_PTR,    0, 1, 8'h00, 1, 1, 8'h04);
    vecs[6]  = mk(REG_DATA,   0, 1, 8'h00, 3, 1, 8'h02);  // slot 4 unchanged
    vecs[7]  = mk(REG_PTR,    0, 1, 8'h00, 1, 1, 8'h05);
    vecs[8]  = mk(REG_KEY,    1, 1, 8'hA5, 0, 0, 8'h00);  // wr+rd ignored
    vecs[9]  = mk(REG_KEY,    1, 0, 8'h5A, 1, 0, 8'h00);
    vecs[10] = mk(REG_KEY,    0, 1, 8'h00, 1, 1, 8'h00);
    vecs[11] = mk(REG_KEY,    1, 0, 8'hA5, 1, 0, 8'h00);
    vecs[12] = mk(REG_KEY,    0, 1, 8'h00, 1, 1, 8'h01);
    vecs[13] = mk(REG_STATUS, 0, 1, 8'h00, 1, 1, 8'h03);
    vecs[14] = mk(REG_STATUS, 1, 0, 8'hFF, 1, 0, 8'h00);
    vecs[15] = mk(REG_PTR,    1, 0, 8'h0F, 1, 0, 8'h00);  // only [2:0] kept
    vecs[16] = mk(REG_DATA,   0, 1, 8'h00, 3, 1, 8'h05);  // slot 7
    vecs[17] = mk(REG_PTR,    0, 1, 8'h00, 1, 1, 8'h00);  // wrapped

    system_reset_n = 1'b0;
    host_addr      = REG_PTR;
    host_wr        = 1'b0;
    host_rd        = 1'b1;      // held through reset and INIT
    host_wdata     = 8'h00;
    a2_slot_busy   = 1'b0;

    step();
    step();
    check("reset cfg_slot",   {5'b0, cfg_slot},   8'h00);
    check("reset cfg_card",   cfg_card,           8'h00);
    check("reset cfg_wr",     {7'b0, cfg_wr},     8'h00);
    check("reset host_rdata", host_rdata,         8'h00);
    check("reset host_ready", {7'b0, host_ready}, 8'h00);
    check("reset init_done",  {7'b0, init_done},  8'h00);

    system_reset_n = 1'b1;
    check_init("boot");

    for (int i = 0; i < 18; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Deferred write: busy for 5 cycles from the request, strobe on the 6th.
    do_op(mk(REG_PTR, 1, 0, 8'h07, 1, 0, 8'h00), "defer ptr");
    host_addr = REG_DATA; host_wdata = 8'h01; host_wr = 1'b1; a2_slot_busy = 1'b1;
    step();
    host_wr = 1'b0;
    check("defer c1 cfg_wr", {7'b0, cfg_wr},     8'h00);
    check("defer c1 ready",  {7'b0, host_ready}, 8'h00);
    for (int k = 2; k <= 5; k++) begin
      step();
      check("defer wait cfg_wr", {7'b0, cfg_wr},     8'h00);
      check("defer wait ready",  {7'b0, host_ready}, 8'h00);
    end
    a2_slot_busy = 1'b0;
    step();
    check("defer cfg_wr",   {7'b0, cfg_wr},     8'h01);
    check("defer cfg_slot", {5'b0, cfg_slot},   8'h07);
    check("defer cfg_card", cfg_card,           8'h01);
    check("defer ready",    {7'b0, host_ready}, 8'h01);
    step();
    check("defer strobe end", {7'b0, cfg_wr},     8'h00);
    check("defer ready end",  {7'b0, host_ready}, 8'h00);
    do_op(mk(REG_PTR, 0, 1, 8'h00, 1, 1, 8'h00), "defer ptr wrap");

    // Back-to-back DATA reads from slot 6, then the just-written slot 7.
    do_op(mk(REG_PTR,  1, 0, 8'h06, 1, 0, 8'h00), "rd2 ptr");
    do_op(mk(REG_DATA, 0, 1, 8'h00, 3, 1, 8'h00), "rd2 slot6");
    do_op(mk(REG_DATA, 0, 1, 8'h00, 3, 1, 8'h01), "rd2 slot7");
    do_op(mk(REG_PTR,  0, 1, 8'h00, 1, 1, 8'h00), "rd2 ptr after");

    // Forced write: bus never goes quiet; STATUS polled mid-wait.
    do_op(mk(REG_PTR, 1, 0, 8'h02, 1, 0, 8'h00), "force ptr");
    host_addr = REG_DATA; host_wdata = 8'h09; host_wr = 1'b1; a2_slot_busy = 1'b1;
    step();
    host_wr = 1'b0;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 4) begin host_addr = REG_STATUS; host_rd = 1'b1; end
      step();
      host_rd = 1'b0;
      if (cfg_wr) begin
        found = k;
        break;
      end
      check("force wait ready", {7'b0, host_ready}, (k == 4) ? 8'h01 : 8'h00);
      if (k == 4) check("force status rdata", host_rdata, 8'h07);
    end
    check("force wait cycles", 8'(found), 8'd16);
    check("force cfg_slot",    {5'b0, cfg_slot},   8'h02);
    check("force cfg_card",    cfg_card,           8'h09);
    check("force ready",       {7'b0, host_ready}, 8'h01);
    step();
    a2_slot_busy = 1'b0;
    do_op(mk(REG_PTR,  1, 0, 8'h02, 1, 0, 8'h00), "force ptr2");
    do_op(mk(REG_DATA, 0, 1, 8'h00, 3, 1, 8'h09), "force readback");

    // Reset while a write waits: write lost, table reloaded, relocked.
    do_op(mk(REG_PTR, 1, 0, 8'h00, 1, 0, 8'h00), "rst ptr");
    host_addr = REG_DATA; host_wdata = 8'h33; host_wr = 1'b1; a2_slot_busy = 1'b1;
    step();
    host_wr = 1'b0;
    step();
    step();
    check("rst pre cfg_wr", {7'b0, cfg_wr}, 8'h00);
    system_reset_n = 1'b0;
    #1;
    check("rst async init_done", {7'b0, init_done},  8'h00);
    check("rst async cfg_wr",    {7'b0, cfg_wr},     8'h00);
    check("rst async ready",     {7'b0, host_ready}, 8'h00);
    step();
    step();
    system_reset_n = 1'b1;
    host_addr = REG_PTR;
    host_rd   = 1'b1;
    check_init("reinit");
    a2_slot_busy = 1'b0;
    do_op(mk(REG_KEY,    0, 1, 8'h00, 1, 1, 8'h00), "reinit key");
    do_op(mk(REG_STATUS, 0, 1, 8'h00, 1, 1, 8'h01), "reinit status");
    do_op(mk(REG_PTR,    0, 1, 8'h00, 1, 1, 8'h00), "reinit ptr");
    do_op(mk(REG_DATA,   0, 1, 8'h00, 3, 1, 8'h00), "reinit slot0");
    do_op(mk(REG_PTR,    1, 0, 8'h02, 1, 0, 8'h00), "reinit ptr2");
    do_op(mk(REG_DATA,   0, 1, 8'h00, 3, 1, 8'h00), "reinit slot2");
    do_op(mk(REG_PTR,    1, 0, 8'h07, 1, 0, 8'h00), "reinit ptr7");
    do_op(mk(REG_DATA,   0, 1, 8'h00, 3, 1, 8'h05), "reinit slot7");
    do_op(mk(REG_DATA,   1, 0, 8'h44, 1, 0, 8'h00), "reinit locked wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
